// File: rtl/fir_pkg.sv
// Shared constants, state encoding and helpers for the FIR tap loader front end.
package fir_pkg;

   localparam int N_TAPS    = 11;
   localparam int SAMPLE_W  = 32;
   localparam int COEF_W    = 16;
   localparam int TAP_RAM_W = 32;
   localparam logic [3:0] WE_ALL = 4'b1111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } state_t;

   // Replicate bit w-1 of v into every bit above it (w is the source width).
   function automatic logic [TAP_RAM_W-1:0] sign_extend(input logic [TAP_RAM_W-1:0] v,
                                                         input int w);
      logic [TAP_RAM_W-1:0] r;
      r = v;
      for (int i = 0; i < TAP_RAM_W; i++) begin
         if (i >= w) r[i] = v[w-1];
      end
      return r;
   endfunction

endpackage

// File: rtl/fir_tap_loader.sv
// Loads a full coefficient set into fir_bram and gates its sample input
// until a complete, valid tap set is present.
module fir_tap_loader
   import fir_pkg::*;
#(
   parameter int N          = N_TAPS,
   parameter int WIDTH      = SAMPLE_W,
   parameter int COEF_WIDTH = COEF_W,
   parameter int IDX_W      = $clog2(N)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [COEF_WIDTH-1:0] coef_in,
   input  logic                  coef_valid,
   output logic                  coef_ready,
   output logic [TAP_RAM_W-1:0]  tap_ram_in,
   output logic [3:0]            tap_ram_we,
   output logic [IDX_W-1:0]      tap_idx,
   input  logic [WIDTH-1:0]      s_data,
   input  logic                  s_valid,
   output logic [WIDTH-1:0]      x_out,
   output logic                  busy,
   output logic                  done
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   state_t                 state_q;
   logic [IDX_W-1:0]       count_q;
   logic [TAP_RAM_W-1:0]   tap_ram_in_q;
   logic [3:0]             tap_ram_we_q;
   logic [IDX_W-1:0]       tap_idx_q;
   logic [WIDTH-1:0]       x_out_q;
   logic                   busy_q;
   logic                   done_q;

   logic                   accept_d;
   logic [TAP_RAM_W-1:0]   coef_ext_d;

   // Handshake and coefficient widening; ready depends on state only.
   always_comb begin
      coef_ready = (state_q == LOAD);
      accept_d   = coef_valid && (state_q == LOAD);
      coef_ext_d = sign_extend(TAP_RAM_W'(coef_in), COEF_WIDTH);
   end

   // Load FSM, tap counter, write pulse generation and gated sample register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         count_q      <= '0;
         tap_ram_in_q <= '0;
         tap_ram_we_q <= '0;
         tap_idx_q    <= '0;
         x_out_q      <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         tap_ram_we_q <= '0;
         done_q       <= 1'b0;
         // Zeros outside RUN flush the downstream delay line.
         x_out_q      <= (state_q == RUN && s_valid) ? s_data : '0;

         if (start) begin
            // Start always (re)begins a load; a coefficient offered now is dropped.
            state_q <= LOAD;
            busy_q  <= 1'b1;
            count_q <= '0;
         end else if (accept_d) begin
            tap_ram_in_q <= coef_ext_d;
            tap_ram_we_q <= WE_ALL;
            tap_idx_q    <= count_q;
            if (count_q == LAST_IDX) begin
               state_q <= RUN;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               count_q <= '0;
            end else begin
               count_q <= count_q + 1'b1;
            end
         end
      end
   end

   assign tap_ram_in = tap_ram_in_q;
   assign tap_ram_we = tap_ram_we_q;
   assign tap_idx    = tap_idx_q;
   assign x_out      = x_out_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule
